gray_rx_decoder: RTL



---
 rtl/gray_rx_pkg.sv | 28 ++
 rtl/gray_sync.sv | 42 ++++
 rtl/gray_rx_decoder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gray_rx_pkg.sv
// ---------------------------------------------------------------------------
// gray_rx_pkg
// Shared constants and helpers for Gray-code receivers.
//   ERR_CNT_W   : width of the illegal-jump counter
//   ERR_CNT_MAX : saturation value of the illegal-jump counter
//   GRAY_MAX_W  : widest Gray word gray2bin() accepts
//   gray2bin()  : Gray to binary conversion. Narrower words are passed
//                 zero-extended, which leaves the low bits of the result
//                 unchanged.
// ---------------------------------------------------------------------------
package gray_rx_pkg;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;
    localparam int GRAY_MAX_W = 32;

    // Each binary bit is the XOR of its Gray bit with every Gray bit above it.
    // Zero bits above the real MSB contribute nothing to that XOR.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// ---------------------------------------------------------------------------
// gray_sync
// Multi-flop synchroniser for a Gray-coded bus. Every stage clears to zero
// under reset.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low
//   din   : asynchronous Gray word
//   dout  : Gray word after STAGES flops
// ---------------------------------------------------------------------------
module gray_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/gray_rx_decoder.sv
// ---------------------------------------------------------------------------
// gray_rx_decoder
// Receives a Gray-coded bus from another clock domain. It synchronises the
// bus, converts it to binary and classifies every change as an up-step, a
// down-step or an illegal jump.
//   clk       : rising-edge clock
//   rst_n     : synchronous reset, active-low
//   gray_in   : Gray word, may be asynchronous to clk
//   bin_out   : binary value of the synchronised word
//   bin_valid : bin_out is meaningful. Sticky until reset.
//   step_up   : 1-cycle pulse, new == prev + 1 (mod 2^WIDTH)
//   step_down : 1-cycle pulse, new == prev - 1 (mod 2^WIDTH)
//   err_jump  : 1-cycle pulse, new value is not within one step of prev
//   err_count : saturating illegal-jump counter
// Optional feature: define GRAY_RX_ERR_CNT_EN to build the illegal-jump
// counter. Without that macro, err_count is tied to zero.
// ---------------------------------------------------------------------------
module gray_rx_decoder
    import gray_rx_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 err_jump,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0]   sync_gray;
    logic [WIDTH-1:0]   decoded;
    logic [WIDTH-1:0]   diff;
    logic               primed;

    logic [PRIME_W-1:0] prime_cnt_q, prime_cnt_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic               valid_q, valid_d;
    logic               up_q, up_d;
    logic               down_q, down_d;
    logic               err_q, err_d;

    gray_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (gray_in),
        .dout  (sync_gray)
    );

    assign decoded = WIDTH'(gray2bin(GRAY_MAX_W'(sync_gray)));

    // The sync chain holds reset zeros until it has been refilled with words
    // sampled after release. The compare stage waits SYNC_STAGES edges so
    // that those zeros are never loaded or classified.
    assign primed = (prime_cnt_q == PRIME_W'(SYNC_STAGES));

    // The modular difference classifies every change. +1 and all-ones are
    // distinct codes for any WIDTH >= 2, so the three strobes are mutually
    // exclusive. For WIDTH=2 the opposite value (diff = 2) is an error.
    always_comb begin
        prime_cnt_d = prime_cnt_q;
        bin_d       = bin_q;
        valid_d     = valid_q;
        up_d        = 1'b0;
        down_d      = 1'b0;
        err_d       = 1'b0;
        diff        = decoded - bin_q;

        if (!primed) begin
            prime_cnt_d = prime_cnt_q + PRIME_W'(1);
        end else begin
            bin_d   = decoded;
            valid_d = 1'b1;
            if (valid_q) begin
                up_d   = (diff == WIDTH'(1));
                down_d = (diff == {WIDTH{1'b1}});
                err_d  = (diff != '0) && !up_d && !down_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prime_cnt_q <= '0;
            bin_q       <= '0;
            valid_q     <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prime_cnt_q <= prime_cnt_d;
            bin_q       <= bin_d;
            valid_q     <= valid_d;
            up_q        <= up_d;
            down_q      <= down_d;
            err_q       <= err_d;
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = valid_q;
    assign step_up   = up_q;
    assign step_down = down_q;
    assign err_jump  = err_q;

`ifdef GRAY_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // The counter advances together with the err_jump pulse it counts.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule
